// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper move controller and its phase generator.
//   - default widths for step count, rate divider and position
//   - move FSM state encoding
//   - one-hot coil phase constants and a phase -> coil decode helper
package stepper_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int DIV_W_DEF = 8;
    localparam int POS_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [3:0] PH0 = 4'b0001;
    localparam logic [3:0] PH1 = 4'b0010;
    localparam logic [3:0] PH2 = 4'b0100;
    localparam logic [3:0] PH3 = 4'b1000;

    function automatic logic [3:0] phase_onehot(input logic [1:0] ph);
        logic [3:0] oh;
        case (ph)
            2'd0:    oh = PH0;
            2'd1:    oh = PH1;
            2'd2:    oh = PH2;
            default: oh = PH3;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/stepper_phase_gen.sv
// 2-bit coil phase counter with one-hot coil decode.
// Ports:
//   drv_clk  - clock
//   reset    - synchronous, active-high reset (phase 0, coils off)
//   step     - advance the phase by one this edge
//   dir      - 1 = phase +1, 0 = phase -1 (mod 4)
//   coil_en  - coils energised in the next cycle
//   coil     - registered one-hot coil drive (0 when not enabled)
//   home     - registered flag, phase index == 0
module stepper_phase_gen
    import stepper_pkg::*;
(
    input  logic       drv_clk,
    input  logic       reset,
    input  logic       step,
    input  logic       dir,
    input  logic       coil_en,
    output logic [3:0] coil,
    output logic       home
);

    logic [1:0] phase;
    logic [1:0] phase_next;

    // 2-bit arithmetic gives the 3->0 and 0->3 wrap for free
    always_comb begin
        phase_next = phase;
        if (step) begin
            phase_next = dir ? (phase + 2'd1) : (phase - 2'd1);
        end
    end

    // coil and home are registered from the next-phase value so they
    // line up with the phase register in the same cycle
    always_ff @(posedge drv_clk) begin
        if (reset) begin
            phase <= 2'd0;
            coil  <= 4'b0000;
            home  <= 1'b1;
        end else begin
            phase <= phase_next;
            coil  <= coil_en ? phase_onehot(phase_next) : 4'b0000;
            home  <= (phase_next == 2'd0);
        end
    end

endmodule

// File: rtl/stepper_move_ctrl.sv
// Move-level controller for a 4-phase unipolar stepper. Accepts a counted,
// rate-limited move over valid/ready, sequences the coil phases and tracks
// signed absolute position.
// Ports:
//   drv_clk, reset      - clock, synchronous active-high reset
//   cmd_valid/cmd_ready - command handshake (ready only in IDLE)
//   cmd_dir             - 1 = forward, 0 = reverse
//   cmd_steps           - steps to issue (0 completes immediately)
//   rate_div            - step period minus 1, in drv_clk cycles
//   abort               - end the current move early, no further step
//   busy, done, aborted - move in progress / end pulse / end-by-abort flag
//   motor_drv           - one-hot coil drive, 0 in IDLE
//   position            - two's-complement step position (wraps)
//   home                - phase index == 0
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | coils off, waiting for a command; abort ignored
// ST_RUN  | counting down the step timer, stepping on terminal count
// ST_DONE | one-cycle completion pulse, then back to IDLE
module stepper_move_ctrl
    import stepper_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DIV_W = DIV_W_DEF,
    parameter int POS_W = POS_W_DEF
) (
    input  logic             drv_clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0] rate_div,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [3:0]       motor_drv,
    output logic [POS_W-1:0] position,
    output logic             home
);

    state_e           state;
    state_e           state_nxt;
    logic             accept;
    logic             step_due;
    logic             abort_exit;

    logic             dir_q;
    logic [DIV_W-1:0] rate_q;
    logic [DIV_W-1:0] timer;
    logic [CNT_W-1:0] remaining;
    logic [POS_W-1:0] pos_q;

    // abort is checked before the step-due test so it wins on a tie
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        step_due   = 1'b0;
        abort_exit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = (cmd_steps == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    abort_exit = 1'b1;
                    state_nxt  = ST_DONE;
                end else if (timer == '0) begin
                    step_due = 1'b1;
                    if (remaining == CNT_W'(1)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge drv_clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            dir_q     <= 1'b0;
            rate_q    <= '0;
            timer     <= '0;
            remaining <= '0;
            pos_q     <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cmd_ready <= (state_nxt == ST_IDLE);
            busy      <= (state_nxt == ST_RUN);
            done      <= (state_nxt == ST_DONE);
            aborted   <= (state_nxt == ST_DONE) && abort_exit;

            if (accept) begin
                dir_q     <= cmd_dir;
                rate_q    <= rate_div;
                remaining <= cmd_steps;
                timer     <= rate_div;
            end else if (state == ST_RUN && !abort) begin
                if (step_due) begin
                    remaining <= remaining - CNT_W'(1);
                    timer     <= rate_q;
                    pos_q     <= dir_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
                end else begin
                    timer <= timer - DIV_W'(1);
                end
            end
        end
    end

    assign position = pos_q;

    stepper_phase_gen u_phase_gen (
        .drv_clk (drv_clk),
        .reset   (reset),
        .step    (step_due),
        .dir     (dir_q),
        .coil_en (state_nxt != ST_IDLE),
        .coil    (motor_drv),
        .home    (home)
    );

endmodule

// File: tb/tb_stepper_move_ctrl.sv
module tb_stepper_move_ctrl;

    logic        drv_clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [7:0]  cmd_steps;
    logic [7:0]  rate_div;
    logic        abort;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [3:0]  motor_drv;
    logic [15:0] position;
    logic        home;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] pos;
        logic [3:0]  drv;
        logic        ab;
    } exp_t;

    exp_t        exp_q[$];
    int          m_phase;
    logic [15:0] m_pos;

    stepper_move_ctrl #(.CNT_W(8), .DIV_W(8), .POS_W(16)) dut (
        .drv_clk   (drv_clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_steps (cmd_steps),
        .rate_div  (rate_div),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .motor_drv (motor_drv),
        .position  (position),
        .home      (home)
    );

    always #5 drv_clk = ~drv_clk;

    function automatic logic [3:0] ph_bits(input int p);
        logic [3:0] one;
        one = 4'b0001;
        return one << p;
    endfunction

    task automatic do_reset;
        @(negedge drv_clk);
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_steps = 8'd0;
        rate_div  = 8'd0;
        abort     = 1'b0;
        repeat (2) @(negedge drv_clk);
        reset   = 1'b0;
        m_phase = 0;
        m_pos   = 16'h0000;
        exp_q.delete();
    endtask

    // Offers a command from a negedge and returns at the negedge right after
    // the accept edge. The expected end-of-move record is pushed here.
    task automatic issue(input logic dir, input int steps, input int rate,
                         input int exp_steps, input logic exp_ab);
        exp_t e;
        for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge drv_clk);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_steps = 8'(steps);
        rate_div  = 8'(rate);
        for (int i = 0; i < exp_steps; i++) begin
            m_pos   = dir ? m_pos + 16'd1 : m_pos - 16'd1;
            m_phase = dir ? (m_phase + 1) % 4 : (m_phase + 3) % 4;
        end
        e.pos = m_pos;
        e.drv = ph_bits(m_phase);
        e.ab  = exp_ab;
        exp_q.push_back(e);
        @(negedge drv_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge drv_clk);
        end
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if ({motor_drv, busy, done, aborted, cmd_ready, home, position} !==
            {4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000}) begin
            failures++;
            $display("FAIL reset_state: drv=%b busy=%b done=%b ab=%b rdy=%b home=%b pos=%h, want drv=0000 busy=0 done=0 ab=0 rdy=1 home=1 pos=0000",
                     motor_drv, busy, done, aborted, cmd_ready, home, position);
        end
    endtask

    task automatic test_fwd_basic;
        logic [3:0] seq [4];
        exp_t e;
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;
        issue(1'b1, 3, 0, 3, 1'b0);
        checks++;
        if ({motor_drv, busy, cmd_ready, done} !== {seq[0], 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL fwd_accept: drv=%b busy=%b rdy=%b done=%b, want drv=0001 busy=1 rdy=0 done=0",
                     motor_drv, busy, cmd_ready, done);
        end
        for (int i = 1; i <= 3; i++) begin
            @(negedge drv_clk);
            checks++;
            if ({motor_drv, position, done} !== {seq[i], 16'(i), (i == 3)}) begin
                failures++;
                $display("FAIL fwd_step%0d: drv=%b pos=%h done=%b, want drv=%b pos=%h done=%b",
                         i, motor_drv, position, done, seq[i], 16'(i), (i == 3));
            end
        end
        e = exp_q.pop_front();
        checks++;
        if ({position, motor_drv, aborted, busy} !== {e.pos, e.drv, e.ab, 1'b0}) begin
            failures++;
            $display("FAIL fwd_done_rec: pos=%h drv=%b ab=%b busy=%b, want pos=%h drv=%b ab=%b busy=0",
                     position, motor_drv, aborted, busy, e.pos, e.drv, e.ab);
        end
        @(negedge drv_clk);
        checks++;
        if ({motor_drv, cmd_ready, done} !== {4'b0000, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL fwd_idle: drv=%b rdy=%b done=%b, want drv=0000 rdy=1 done=0",
                     motor_drv, cmd_ready, done);
        end
    endtask

    task automatic test_reverse;
        exp_t e;
        do_reset;
        issue(1'b0, 2, 0, 2, 1'b0);
        @(negedge drv_clk);
        checks++;
        if ({motor_drv, position, home} !== {4'b1000, 16'hFFFF, 1'b0}) begin
            failures++;
            $display("FAIL rev_step1: drv=%b pos=%h home=%b, want drv=1000 pos=ffff home=0",
                     motor_drv, position, home);
        end
        @(negedge drv_clk);
        e = exp_q.pop_front();
        checks++;
        if ({done, position, motor_drv, aborted, home} !== {1'b1, e.pos, e.drv, e.ab, 1'b0}) begin
            failures++;
            $display("FAIL rev_done_rec: done=%b pos=%h drv=%b ab=%b home=%b, want done=1 pos=%h drv=%b ab=%b home=0",
                     done, position, motor_drv, aborted, home, e.pos, e.drv, e.ab);
        end
        @(negedge drv_clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL rev_done_width: done=%b one cycle later, want 0", done);
        end
    endtask

    task automatic test_cadence;
        logic [3:0] prev;
        logic       changed;
        exp_t e;
        issue(1'b1, 2, 4, 2, 1'b0);
        prev = motor_drv;
        for (int c = 1; c <= 11; c++) begin
            @(negedge drv_clk);
            changed = (motor_drv !== prev) && (motor_drv !== 4'b0000);
            checks++;
            if ({changed, busy, done} !== {(c == 5 || c == 10), (c <= 9), (c == 10)}) begin
                failures++;
                $display("FAIL cadence_c%0d: step=%b busy=%b done=%b, want step=%b busy=%b done=%b",
                         c, changed, busy, done, (c == 5 || c == 10), (c <= 9), (c == 10));
            end
            if (c == 10) begin
                e = exp_q.pop_front();
                checks++;
                if ({position, motor_drv, aborted} !== {e.pos, e.drv, e.ab}) begin
                    failures++;
                    $display("FAIL cadence_done_rec: pos=%h drv=%b ab=%b, want pos=%h drv=%b ab=%b",
                             position, motor_drv, aborted, e.pos, e.drv, e.ab);
                end
            end
            if (motor_drv !== 4'b0000) prev = motor_drv;
        end
    endtask

    task automatic test_zero_steps;
        exp_t e;
        for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge drv_clk);
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_steps = 8'd0;
        rate_div  = 8'd0;
        e.pos = m_pos;
        e.drv = ph_bits(m_phase);
        e.ab  = 1'b0;
        exp_q.push_back(e);
        @(negedge drv_clk);
        e = exp_q.pop_front();
        checks++;
        if ({done, busy, cmd_ready, position, motor_drv, aborted} !==
            {1'b1, 1'b0, 1'b0, e.pos, e.drv, e.ab}) begin
            failures++;
            $display("FAIL zero_done: done=%b busy=%b rdy=%b pos=%h drv=%b ab=%b, want done=1 busy=0 rdy=0 pos=%h drv=%b ab=%b",
                     done, busy, cmd_ready, position, motor_drv, aborted, e.pos, e.drv, e.ab);
        end
        cmd_steps = 8'd5;
        @(negedge drv_clk);
        cmd_valid = 1'b0;
        checks++;
        if ({cmd_ready, busy, done, motor_drv} !== {1'b1, 1'b0, 1'b0, 4'b0000}) begin
            failures++;
            $display("FAIL zero_no_accept_in_done: rdy=%b busy=%b done=%b drv=%b, want rdy=1 busy=0 done=0 drv=0000",
                     cmd_ready, busy, done, motor_drv);
        end
        abort = 1'b1;
        @(negedge drv_clk);
        abort = 1'b0;
        checks++;
        if ({cmd_ready, done, aborted, position} !== {1'b1, 1'b0, 1'b0, m_pos}) begin
            failures++;
            $display("FAIL idle_abort_ignored: rdy=%b done=%b ab=%b pos=%h, want rdy=1 done=0 ab=0 pos=%h",
                     cmd_ready, done, aborted, position, m_pos);
        end
    endtask

    task automatic test_abort;
        exp_t e;
        issue(1'b1, 10, 2, 3, 1'b1);
        repeat (11) @(negedge drv_clk);
        abort = 1'b1;
        @(negedge drv_clk);
        abort = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if ({done, aborted, position, motor_drv} !== {1'b1, 1'b1, e.pos, e.drv}) begin
            failures++;
            $display("FAIL abort_done_rec: done=%b ab=%b pos=%h drv=%b, want done=1 ab=1 pos=%h drv=%b",
                     done, aborted, position, motor_drv, e.pos, e.drv);
        end
        @(negedge drv_clk);
        checks++;
        if ({done, aborted, cmd_ready} !== {1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL abort_after: done=%b ab=%b rdy=%b, want done=0 ab=0 rdy=1",
                     done, aborted, cmd_ready);
        end
    endtask

    task automatic test_reset_mid_move;
        bit saw_done;
        issue(1'b1, 5, 0, 5, 1'b0);
        repeat (2) @(negedge drv_clk);
        reset = 1'b1;
        @(negedge drv_clk);
        reset   = 1'b0;
        m_pos   = 16'h0000;
        m_phase = 0;
        exp_q.delete();
        checks++;
        if ({motor_drv, position, busy, cmd_ready, done, home} !==
            {4'b0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_mid_move: drv=%b pos=%h busy=%b rdy=%b done=%b home=%b, want drv=0000 pos=0000 busy=0 rdy=1 done=0 home=1",
                     motor_drv, position, busy, cmd_ready, done, home);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge drv_clk);
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_done: done pulse seen=%b after reset, want 0", saw_done);
        end
    endtask

    task automatic test_back_to_back_wrap;
        bit   ok;
        int   bad;
        exp_t e;
        bad = 0;
        for (int m = 0; m < 130; m++) begin
            if (m < 128)       issue(1'b1, 255, 0, 255, 1'b0);
            else if (m == 128) issue(1'b1, 127, 0, 127, 1'b0);
            else               issue(1'b1, 1, 0, 1, 1'b0);
            wait_done(ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL b2b_timeout: move %0d no done within bound, want done", m);
                break;
            end
            e = exp_q.pop_front();
            checks++;
            if ({position, motor_drv, aborted} !== {e.pos, e.drv, e.ab}) begin
                failures++;
                bad++;
                if (bad < 4)
                    $display("FAIL b2b_done_rec%0d: pos=%h drv=%b ab=%b, want pos=%h drv=%b ab=%b",
                             m, position, motor_drv, aborted, e.pos, e.drv, e.ab);
            end
            if (m == 128) begin
                checks++;
                if (position !== 16'h7FFF) begin
                    failures++;
                    $display("FAIL pos_max: pos=%h, want 7fff", position);
                end
            end
        end
        checks++;
        if (position !== 16'h8000) begin
            failures++;
            $display("FAIL pos_wrap: pos=%h, want 8000", position);
        end
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_steps = 8'd0;
        rate_div  = 8'd0;
        abort     = 1'b0;
        test_reset;
        test_fwd_basic;
        test_reverse;
        test_cadence;
        test_zero_steps;
        test_abort;
        test_reset_mid_move;
        test_back_to_back_wrap;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
